elevator_car_model: RTL and testbench

ELEVATOR_CAR_MODEL -- requirements
Module: elevator_car_model

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/elevator_car_model_if.sv | 28 ++
 rtl/elevator_door_model.sv | 58 +++++
 rtl/elevator_car_model.sv | 107 ++++++++++
 tb/tb_elevator_car_model.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car model: motor/door commands and door FSM states.
package elevator_pkg;

  typedef enum logic [1:0] {
    MotorStop    = 2'b00,
    MotorUp      = 2'b01,
    MotorDown    = 2'b10,
    MotorIllegal = 2'b11
  } motor_cmd_e;

  typedef enum logic [1:0] {
    DoorStop    = 2'b00,
    DoorOpen    = 2'b01,
    DoorClose   = 2'b10,
    DoorIllegal = 2'b11
  } door_cmd_e;

  typedef enum logic [2:0] {
    StClosed  = 3'd0,
    StOpening = 3'd1,
    StOpen    = 3'd2,
    StClosing = 3'd3,
    StHalted  = 3'd4
  } door_state_e;

endpackage

// File: rtl/elevator_car_model_if.sv
// Command/status bundle between a controller (master) and the car model (slave).
interface elevator_car_model_if;
  import elevator_pkg::*;

  logic [1:0]  elevator_control;
  logic [1:0]  door_motor_control;
  logic        fault_clr;
  logic [3:0]  current_floor;
  logic        door_open_sense;
  logic        door_close_sense;
  logic        overtravel_fault;
  logic        illegal_cmd_fault;
  logic        door_ajar_motion_fault;
  logic        car_moving;
  door_state_e door_state;

  modport master (
    output elevator_control, door_motor_control, fault_clr,
    input  current_floor, door_open_sense, door_close_sense, overtravel_fault,
           illegal_cmd_fault, door_ajar_motion_fault, car_moving, door_state
  );

  modport slave (
    input  elevator_control, door_motor_control, fault_clr,
    output current_floor, door_open_sense, door_close_sense, overtravel_fault,
           illegal_cmd_fault, door_ajar_motion_fault, car_moving, door_state
  );
endinterface

// File: rtl/elevator_door_model.sv
// Door position counter, door FSM and fully-open/fully-closed sensing.
module elevator_door_model
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_TRAVEL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  door_cmd_e   door_cmd_i,
  output logic        door_open_sense_o,
  output logic        door_close_sense_o,
  output door_state_e door_state_o
);

  localparam logic [7:0] DoorMax = 8'(DOOR_TRAVEL_CYCLES);

  logic [7:0]  door_pos_q, door_pos_d;
  door_state_e state_q, state_d;

  // Saturating position update; FSM follows the position reached this edge.
  always_comb begin
    door_pos_d = door_pos_q;
    state_d    = state_q;
    case (door_cmd_i)
      DoorOpen: begin
        if (door_pos_q != DoorMax) door_pos_d = door_pos_q + 8'd1;
        state_d = (door_pos_d == DoorMax) ? StOpen : StOpening;
      end
      DoorClose: begin
        if (door_pos_q != 8'd0) door_pos_d = door_pos_q - 8'd1;
        state_d = (door_pos_d == 8'd0) ? StClosed : StClosing;
      end
      default: begin
        // Stop (or illegal, treated as stop) freezes a door in mid travel.
        if (state_q == StOpening || state_q == StClosing) state_d = StHalted;
      end
    endcase
  end

  // Door state register with synchronous reset to fully closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      door_pos_q <= 8'd0;
      state_q    <= StClosed;
    end else begin
      door_pos_q <= door_pos_d;
      state_q    <= state_d;
    end
  end

  // Sense outputs decode the position directly.
  always_comb begin
    door_close_sense_o = (door_pos_q == 8'd0);
    door_open_sense_o  = (door_pos_q == DoorMax);
    door_state_o       = state_q;
  end

endmodule

// File: rtl/elevator_car_model.sv
// Elevator car plant model: floor stepping, shaft limits and sticky fault reporting.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 1,
  parameter int unsigned DOOR_TRAVEL_CYCLES  = 4,
  parameter int unsigned BOTTOM_FLOOR        = 1,
  parameter int unsigned TOP_FLOOR           = 15
) (
  input logic                 clk,
  input logic                 rst,
  elevator_car_model_if.slave bus
);

  localparam logic [7:0] FtcLast  = 8'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [3:0] TopFl    = 4'(TOP_FLOOR);
  localparam logic [3:0] BottomFl = 4'(BOTTOM_FLOOR);

  motor_cmd_e motor_cmd;
  door_cmd_e  door_cmd_raw, door_cmd;
  logic       is_up, is_dn, blocked, moving, illegal;
  logic       door_close_sense;
  logic [7:0] eff_cnt;

  logic [3:0] floor_q, floor_d;
  logic [7:0] move_cnt_q, move_cnt_d;
  motor_cmd_e last_cmd_q, last_cmd_d;
  logic       ot_fault_q, ot_fault_d;
  logic       ill_fault_q, ill_fault_d;
  logic       ajar_fault_q, ajar_fault_d;

  // Decode commands and shaft-limit blocking.
  always_comb begin
    motor_cmd    = motor_cmd_e'(bus.elevator_control);
    door_cmd_raw = door_cmd_e'(bus.door_motor_control);
    is_up        = (motor_cmd == MotorUp);
    is_dn        = (motor_cmd == MotorDown);
    blocked      = (is_up && floor_q == TopFl) || (is_dn && floor_q == BottomFl);
    moving       = (is_up || is_dn) && !blocked;
    illegal      = (motor_cmd == MotorIllegal) || (door_cmd_raw == DoorIllegal);
    door_cmd     = (door_cmd_raw == DoorIllegal) ? DoorStop : door_cmd_raw;
  end

  // Floor stepping; a fresh or reversed direction starts its count from zero this cycle.
  always_comb begin
    floor_d    = floor_q;
    move_cnt_d = 8'd0;
    last_cmd_d = MotorStop;
    eff_cnt    = (last_cmd_q == motor_cmd) ? move_cnt_q : 8'd0;
    if (moving) begin
      last_cmd_d = motor_cmd;
      if (eff_cnt == FtcLast) begin
        floor_d = is_up ? floor_q + 4'd1 : floor_q - 4'd1;
      end else begin
        move_cnt_d = eff_cnt + 8'd1;
      end
    end
  end

  // Sticky faults: a fault condition outranks a simultaneous clear.
  always_comb begin
    ot_fault_d   = (ot_fault_q & ~bus.fault_clr) | blocked;
    ill_fault_d  = (ill_fault_q & ~bus.fault_clr) | illegal;
    ajar_fault_d = (ajar_fault_q & ~bus.fault_clr) | ((is_up || is_dn) && !door_close_sense);
  end

  // Floor/fault state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor_q      <= BottomFl;
      move_cnt_q   <= 8'd0;
      last_cmd_q   <= MotorStop;
      ot_fault_q   <= 1'b0;
      ill_fault_q  <= 1'b0;
      ajar_fault_q <= 1'b0;
    end else begin
      floor_q      <= floor_d;
      move_cnt_q   <= move_cnt_d;
      last_cmd_q   <= last_cmd_d;
      ot_fault_q   <= ot_fault_d;
      ill_fault_q  <= ill_fault_d;
      ajar_fault_q <= ajar_fault_d;
    end
  end

  elevator_door_model #(
    .DOOR_TRAVEL_CYCLES(DOOR_TRAVEL_CYCLES)
  ) u_door (
    .clk               (clk),
    .rst               (rst),
    .door_cmd_i        (door_cmd),
    .door_open_sense_o (bus.door_open_sense),
    .door_close_sense_o(door_close_sense),
    .door_state_o      (bus.door_state)
  );

  // Drive status outputs.
  always_comb begin
    bus.current_floor          = floor_q;
    bus.door_close_sense       = door_close_sense;
    bus.overtravel_fault       = ot_fault_q;
    bus.illegal_cmd_fault      = ill_fault_q;
    bus.door_ajar_motion_fault = ajar_fault_q;
    bus.car_moving             = moving;
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// Bench: two cars (floor travel 1 and 3 cycles) driven identically, checked against a model.
module tb_elevator_car_model;
  import elevator_pkg::*;

  localparam int DoorMax = 4;
  localparam int Top     = 15;
  localparam int Bottom  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   started = 0;

  always #5 clk = ~clk;

  elevator_car_model_if if_a ();
  elevator_car_model_if if_b ();

  elevator_car_model dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a)
  );

  elevator_car_model #(
    .FLOOR_TRAVEL_CYCLES(3)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b)
  );

  // Behavioural model, index 0 = car A (1 cycle/floor), 1 = car B (3 cycles/floor).
  int ftc [2] = '{1, 3};
  int m_floor [2];
  int m_run [2];    // consecutive unblocked cycles in m_dir since the last step
  int m_dir [2];    // 0 none, 1 up, 2 down
  int m_pos [2];
  door_state_e m_st [2];
  bit m_ot [2], m_ill [2], m_ajar [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int ctrl, dcmd;
    bit clr, up, dn, blk, ill, ajar;
    ctrl = int'(if_a.elevator_control);
    dcmd = int'(if_a.door_motor_control);
    clr  = if_a.fault_clr;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_floor[k] = Bottom; m_run[k] = 0; m_dir[k] = 0; m_pos[k] = 0;
        m_st[k] = StClosed; m_ot[k] = 0; m_ill[k] = 0; m_ajar[k] = 0;
        started = 1;
      end else begin
        up   = (ctrl == 1);
        dn   = (ctrl == 2);
        blk  = (up && m_floor[k] == Top) || (dn && m_floor[k] == Bottom);
        ill  = (ctrl == 3) || (dcmd == 3);
        ajar = (up || dn) && (m_pos[k] != 0);
        if ((up || dn) && !blk) begin
          m_run[k] = (m_dir[k] == ctrl) ? m_run[k] + 1 : 1;
          m_dir[k] = ctrl;
          if (m_run[k] == ftc[k]) begin
            m_floor[k] = up ? m_floor[k] + 1 : m_floor[k] - 1;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
          m_dir[k] = 0;
        end
        if (dcmd == 1) begin
          if (m_pos[k] < DoorMax) m_pos[k]++;
          m_st[k] = (m_pos[k] == DoorMax) ? StOpen : StOpening;
        end else if (dcmd == 2) begin
          if (m_pos[k] > 0) m_pos[k]--;
          m_st[k] = (m_pos[k] == 0) ? StClosed : StClosing;
        end else if (m_st[k] == StOpening || m_st[k] == StClosing) begin
          m_st[k] = StHalted;
        end
        m_ot[k]   = (m_ot[k] && !clr) || blk;
        m_ill[k]  = (m_ill[k] && !clr) || ill;
        m_ajar[k] = (m_ajar[k] && !clr) || ajar;
      end
    end
  end

  task automatic cmp(input int k, input logic [3:0] fl, input logic os, input logic cs,
                     input logic ot, input logic il, input logic aj, input logic mv,
                     input door_state_e st);
    int ctrl;
    bit exp_mv;
    ctrl   = int'(if_a.elevator_control);
    exp_mv = (ctrl == 1 && m_floor[k] != Top) || (ctrl == 2 && m_floor[k] != Bottom);
    chk($sformatf("car%0d floor", k), int'(fl), m_floor[k]);
    chk($sformatf("car%0d open_sense", k), int'(os), int'(m_pos[k] == DoorMax));
    chk($sformatf("car%0d close_sense", k), int'(cs), int'(m_pos[k] == 0));
    chk($sformatf("car%0d overtravel", k), int'(ot), int'(m_ot[k]));
    chk($sformatf("car%0d illegal", k), int'(il), int'(m_ill[k]));
    chk($sformatf("car%0d ajar", k), int'(aj), int'(m_ajar[k]));
    chk($sformatf("car%0d car_moving", k), int'(mv), int'(exp_mv));
    chk($sformatf("car%0d door_state", k), int'(st), int'(m_st[k]));
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      cmp(0, if_a.current_floor, if_a.door_open_sense, if_a.door_close_sense,
          if_a.overtravel_fault, if_a.illegal_cmd_fault, if_a.door_ajar_motion_fault,
          if_a.car_moving, if_a.door_state);
      cmp(1, if_b.current_floor, if_b.door_open_sense, if_b.door_close_sense,
          if_b.overtravel_fault, if_b.illegal_cmd_fault, if_b.door_ajar_motion_fault,
          if_b.car_moving, if_b.door_state);
    end
  end

  // One cycle of stimulus applied to both cars; returns just after the edge.
  task automatic apply(input logic [1:0] c, input logic [1:0] d, input logic clr, input logic r);
    @(negedge clk);
    #1;
    if_a.elevator_control   = c;
    if_a.door_motor_control = d;
    if_a.fault_clr          = clr;
    if_b.elevator_control   = c;
    if_b.door_motor_control = d;
    if_b.fault_clr          = clr;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.elevator_control = 2'b00; if_a.door_motor_control = 2'b00; if_a.fault_clr = 1'b0;
    if_b.elevator_control = 2'b00; if_b.door_motor_control = 2'b00; if_b.fault_clr = 1'b0;

    apply(2'b00, 2'b00, 1'b0, 1'b1);
    apply(2'b00, 2'b00, 1'b0, 1'b1);
    chk("reset floor", int'(if_a.current_floor), 1);
    chk("reset close_sense", int'(if_a.door_close_sense), 1);
    chk("reset door_state", int'(if_a.door_state), int'(StClosed));

    // UP three cycles: 1 -> 2 -> 3 -> 4 on car A; car B steps once.
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("up1 floor", int'(if_a.current_floor), 2);
    chk("up1 car_moving", int'(if_a.car_moving), 1);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("up2 floor", int'(if_a.current_floor), 3);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("up3 floor", int'(if_a.current_floor), 4);
    chk("b up3 floor", int'(if_b.current_floor), 2);
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    chk("stop floor", int'(if_a.current_floor), 4);

    // UP 2, DOWN 1, UP 3: car B only steps on the third consecutive UP.
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("b partial up", int'(if_b.current_floor), 2);
    apply(2'b10, 2'b00, 1'b0, 1'b0);
    chk("b reversal", int'(if_b.current_floor), 2);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("b two ups", int'(if_b.current_floor), 2);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("b third up", int'(if_b.current_floor), 3);
    chk("a after mix", int'(if_a.current_floor), 8);

    // Door: open 4, close 2, stop, close 2.
    for (int i = 0; i < 4; i++) apply(2'b00, 2'b01, 1'b0, 1'b0);
    chk("door open_sense", int'(if_a.door_open_sense), 1);
    chk("door state open", int'(if_a.door_state), int'(StOpen));
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    chk("halted open_sense", int'(if_a.door_open_sense), 0);
    chk("halted close_sense", int'(if_a.door_close_sense), 0);
    chk("halted state", int'(if_a.door_state), int'(StHalted));
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    chk("closed close_sense", int'(if_a.door_close_sense), 1);

    // Door half open, then UP: ajar fault, car still moves. Then illegal motor command.
    apply(2'b00, 2'b01, 1'b0, 1'b0);
    apply(2'b00, 2'b01, 1'b0, 1'b0);
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("ajar fault", int'(if_a.door_ajar_motion_fault), 1);
    chk("ajar floor", int'(if_a.current_floor), 9);
    apply(2'b11, 2'b00, 1'b0, 1'b0);
    chk("illegal fault", int'(if_a.illegal_cmd_fault), 1);
    chk("illegal floor", int'(if_a.current_floor), 9);
    apply(2'b00, 2'b00, 1'b1, 1'b0);
    chk("clr ajar", int'(if_a.door_ajar_motion_fault), 0);
    chk("clr illegal", int'(if_a.illegal_cmd_fault), 0);
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    apply(2'b00, 2'b11, 1'b0, 1'b0);
    chk("door illegal fault", int'(if_a.illegal_cmd_fault), 1);
    apply(2'b00, 2'b00, 1'b1, 1'b0);

    // Drive to the top and beyond.
    for (int i = 0; i < 8; i++) apply(2'b01, 2'b00, 1'b0, 1'b0);
    chk("top floor", int'(if_a.current_floor), 15);
    chk("top overtravel", int'(if_a.overtravel_fault), 1);
    chk("top car_moving", int'(if_a.car_moving), 0);
    chk("b floor climb", int'(if_b.current_floor), 5);
    apply(2'b01, 2'b00, 1'b1, 1'b0);
    chk("clr vs fault", int'(if_a.overtravel_fault), 1);
    chk("clr vs fault floor", int'(if_a.current_floor), 15);
    apply(2'b00, 2'b00, 1'b1, 1'b0);
    chk("clr overtravel", int'(if_a.overtravel_fault), 0);

    // Reset mid travel and mid door opening.
    apply(2'b10, 2'b01, 1'b0, 1'b0);
    apply(2'b10, 2'b01, 1'b0, 1'b0);
    chk("pre-reset floor", int'(if_a.current_floor), 13);
    apply(2'b01, 2'b01, 1'b0, 1'b1);
    chk("rst floor", int'(if_a.current_floor), 1);
    chk("rst b floor", int'(if_b.current_floor), 1);
    chk("rst close_sense", int'(if_a.door_close_sense), 1);
    chk("rst ajar", int'(if_a.door_ajar_motion_fault), 0);
    chk("rst overtravel", int'(if_a.overtravel_fault), 0);

    // First edge after reset acts normally: DOWN at bottom.
    apply(2'b10, 2'b00, 1'b0, 1'b0);
    chk("bottom floor", int'(if_a.current_floor), 1);
    chk("bottom overtravel", int'(if_a.overtravel_fault), 1);
    apply(2'b00, 2'b00, 1'b1, 1'b0);
    apply(2'b00, 2'b00, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
